// File: rtl/dead_time_monitor.sv
// Dead-time read-back checker for one half-bridge leg: synchronises HS/LS gate
// feedback, measures every gap in CLK cycles and latches shoot-through / short-gap faults.
module dead_time_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned MIN_DT = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             HS,
    input  logic             LS,
    input  logic             CLR,
    output logic [CNT_W-1:0] DT_MEAS,
    output logic             DT_VALID,
    output logic             DT_EDGE,
    output logic [CNT_W-1:0] DT_MIN,
    output logic             DT_VIOL,
    output logic             SHOOT,
    output logic             FAULT
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_DT_C = CNT_W'(MIN_DT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HS_ON  = 3'd1,
        LS_ON  = 3'd2,
        GAP_HL = 3'd3,
        GAP_LH = 3'd4,
        FLT    = 3'd5
    } state_t;

    logic             hs_m, hs_s;
    logic             ls_m, ls_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             both_hi;
    logic             in_gap;
    logic             meas_hl;
    logic             meas_lh;
    logic             meas_any;
    logic [CNT_W-1:0] meas_val;
    logic [CNT_W-1:0] min_base;
    logic             shoot_clr;

    // Two-flop synchronisers for the asynchronous gate feedback.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_m <= 1'b0;
            hs_s <= 1'b0;
            ls_m <= 1'b0;
            ls_s <= 1'b0;
        end else begin
            hs_m <= HS;
            hs_s <= hs_m;
            ls_m <= LS;
            ls_s <= ls_m;
        end
    end

    // Closing-edge decode; a direct hand-over from an ON state measures zero.
    always_comb begin
        both_hi  = hs_s & ls_s;
        in_gap   = (state == GAP_HL) || (state == GAP_LH);
        meas_hl  = 1'b0;
        meas_lh  = 1'b0;
        if (EN && !both_hi) begin
            meas_hl = ((state == GAP_HL) && ls_s) || ((state == HS_ON) && !hs_s && ls_s);
            meas_lh = ((state == GAP_LH) && hs_s) || ((state == LS_ON) && !ls_s && hs_s);
        end
        meas_any = meas_hl | meas_lh;
        meas_val = in_gap ? cnt : CNT_W'(0);
        min_base = CLR ? CNT_MAX : DT_MIN;
        // SHOOT may only be released once the leg is quiet, matching the FLT exit.
        shoot_clr = CLR && ((state != FLT) || (!hs_s && !ls_s));
    end

    // Gap-tracking FSM and saturating gap counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= CNT_W'(0);
        end else if (both_hi) begin
            state <= FLT;
            cnt   <= CNT_W'(0);
        end else if (!EN) begin
            state <= IDLE;
            cnt   <= CNT_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    cnt <= CNT_W'(0);
                    if (hs_s)      state <= HS_ON;
                    else if (ls_s) state <= LS_ON;
                end
                HS_ON: begin
                    if (!hs_s) begin
                        if (ls_s) begin
                            state <= LS_ON;
                            cnt   <= CNT_W'(0);
                        end else begin
                            state <= GAP_HL;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                LS_ON: begin
                    if (!ls_s) begin
                        if (hs_s) begin
                            state <= HS_ON;
                            cnt   <= CNT_W'(0);
                        end else begin
                            state <= GAP_LH;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                GAP_HL: begin
                    if (ls_s) begin
                        state <= LS_ON;
                        cnt   <= CNT_W'(0);
                    end else if (hs_s) begin
                        state <= HS_ON;
                        cnt   <= CNT_W'(0);
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP_LH: begin
                    if (hs_s) begin
                        state <= HS_ON;
                        cnt   <= CNT_W'(0);
                    end else if (ls_s) begin
                        state <= LS_ON;
                        cnt   <= CNT_W'(0);
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FLT: begin
                    cnt <= CNT_W'(0);
                    if (CLR && !hs_s && !ls_s) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= CNT_W'(0);
                end
            endcase
        end
    end

    // Measurement results, statistics and fault latches; a new fault beats CLR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DT_MEAS  <= CNT_W'(0);
            DT_VALID <= 1'b0;
            DT_EDGE  <= 1'b0;
            DT_MIN   <= CNT_MAX;
            DT_VIOL  <= 1'b0;
            SHOOT    <= 1'b0;
            FAULT    <= 1'b0;
        end else begin
            DT_VALID <= meas_any;
            if (meas_any) begin
                DT_MEAS <= meas_val;
                DT_EDGE <= meas_lh;
            end
            if (meas_any && (meas_val < min_base)) DT_MIN <= meas_val;
            else                                   DT_MIN <= min_base;
            DT_VIOL <= (DT_VIOL & ~CLR) | (meas_any & (meas_val < MIN_DT_C));
            SHOOT   <= (SHOOT & ~shoot_clr) | both_hi;
            FAULT   <= DT_VIOL | SHOOT;
        end
    end

endmodule

// File: tb/tb_dead_time_monitor.sv
// Scoreboard bench for dead_time_monitor: expected gaps are queued as stimulus
// closes them and compared whenever DT_VALID pulses.
module tb_dead_time_monitor;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       HS;
    logic       LS;
    logic       CLR;
    logic [7:0] DT_MEAS;
    logic       DT_VALID;
    logic       DT_EDGE;
    logic [7:0] DT_MIN;
    logic       DT_VIOL;
    logic       SHOOT;
    logic       FAULT;

    typedef struct packed {
        logic [7:0] meas;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dead_time_monitor #(.CNT_W(8), .MIN_DT(11)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .HS       (HS),
        .LS       (LS),
        .CLR      (CLR),
        .DT_MEAS  (DT_MEAS),
        .DT_VALID (DT_VALID),
        .DT_EDGE  (DT_EDGE),
        .DT_MIN   (DT_MIN),
        .DT_VIOL  (DT_VIOL),
        .SHOOT    (SHOOT),
        .FAULT    (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_exp(input logic [7:0] meas, input logic dir);
        exp_t e;
        e.meas = meas;
        e.dir  = dir;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clr;
        CLR = 1'b1;
        cyc(1);
        CLR = 1'b0;
    endtask

    // Scoreboard: every DT_VALID must match the oldest queued gap.
    always @(negedge CLK) begin
        if (DT_VALID) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(DT_VALID), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_meas", 32'(DT_MEAS), 32'(e.meas));
                check_eq("sb_edge", 32'(DT_EDGE), 32'(e.dir));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b1; HS = 1'b0; LS = 1'b0; CLR = 1'b0;
        cyc(3);
        check_eq("rst_meas",  32'(DT_MEAS),  32'd0);
        check_eq("rst_valid", 32'(DT_VALID), 32'd0);
        check_eq("rst_edge",  32'(DT_EDGE),  32'd0);
        check_eq("rst_min",   32'(DT_MIN),   32'd255);
        check_eq("rst_viol",  32'(DT_VIOL),  32'd0);
        check_eq("rst_shoot", 32'(SHOOT),    32'd0);
        check_eq("rst_fault", 32'(FAULT),    32'd0);
        RST = 1'b0;
        cyc(2);

        // Clean 15-cycle HS-off to LS-on gap, with pulse timing.
        HS = 1'b1; cyc(20);
        HS = 1'b0; push_exp(8'd15, 1'b0); cyc(15);
        LS = 1'b1;
        cyc(2); check_eq("clean_valid_early", 32'(DT_VALID), 32'd0);
        cyc(1); check_eq("clean_valid_at3",   32'(DT_VALID), 32'd1);
        cyc(1); check_eq("clean_valid_pulse", 32'(DT_VALID), 32'd0);
        check_eq("clean_min",   32'(DT_MIN),  32'd15);
        check_eq("clean_viol",  32'(DT_VIOL), 32'd0);
        check_eq("clean_fault", 32'(FAULT),   32'd0);
        cyc(10);

        // Short 5-cycle LS-off to HS-on gap, then CLR.
        LS = 1'b0; push_exp(8'd5, 1'b1); cyc(5);
        HS = 1'b1; cyc(3);
        check_eq("short_valid", 32'(DT_VALID), 32'd1);
        check_eq("short_viol",  32'(DT_VIOL),  32'd1);
        check_eq("short_fault_lag", 32'(FAULT), 32'd0);
        cyc(1);
        check_eq("short_fault", 32'(FAULT),  32'd1);
        check_eq("short_min",   32'(DT_MIN), 32'd5);
        pulse_clr;
        check_eq("clr_viol", 32'(DT_VIOL), 32'd0);
        check_eq("clr_min",  32'(DT_MIN),  32'd255);
        check_eq("clr_meas", 32'(DT_MEAS), 32'd5);
        cyc(1);
        check_eq("clr_fault", 32'(FAULT), 32'd0);
        cyc(5);

        // Two-cycle overlap, CLR blocked while HS still high.
        LS = 1'b1; cyc(2);
        LS = 1'b0; cyc(3);
        check_eq("ovl_shoot", 32'(SHOOT), 32'd1);
        check_eq("ovl_fault", 32'(FAULT), 32'd1);
        pulse_clr; cyc(1);
        check_eq("ovl_clr_hs_high", 32'(SHOOT), 32'd1);
        HS = 1'b0; cyc(4);
        pulse_clr;
        check_eq("ovl_clr_quiet", 32'(SHOOT), 32'd0);
        cyc(1);
        check_eq("ovl_fault_clr", 32'(FAULT), 32'd0);

        // First edge after FLT exit is not measured; then a saturating gap.
        LS = 1'b1; cyc(10);
        LS = 1'b0; push_exp(8'd255, 1'b1); cyc(300);
        HS = 1'b1; cyc(5);
        check_eq("sat_meas", 32'(DT_MEAS), 32'd255);
        cyc(5);

        // Hand-over on the same raw edge measures zero.
        HS = 1'b0; LS = 1'b1; push_exp(8'd0, 1'b0); cyc(4);
        check_eq("ho_meas", 32'(DT_MEAS), 32'd0);
        check_eq("ho_viol", 32'(DT_VIOL), 32'd1);
        check_eq("ho_min",  32'(DT_MIN),  32'd0);
        pulse_clr; cyc(5);

        // Aborted HS gap leaves the last measurement intact.
        LS = 1'b0; push_exp(8'd12, 1'b1); cyc(12);
        HS = 1'b1; cyc(10);
        HS = 1'b0; cyc(4);
        HS = 1'b1; cyc(10);
        check_eq("abort_meas", 32'(DT_MEAS), 32'd12);
        check_eq("abort_edge", 32'(DT_EDGE), 32'd1);

        // Reset in the middle of a gap.
        HS = 1'b0; cyc(6);
        RST = 1'b1; cyc(2);
        check_eq("rstgap_meas", 32'(DT_MEAS), 32'd0);
        check_eq("rstgap_edge", 32'(DT_EDGE), 32'd0);
        check_eq("rstgap_min",  32'(DT_MIN),  32'd255);
        check_eq("rstgap_viol", 32'(DT_VIOL), 32'd0);
        RST = 1'b0;
        LS = 1'b1; cyc(10);

        // Overlap with the monitor disabled still trips SHOOT.
        EN = 1'b0;
        HS = 1'b1; cyc(4);
        check_eq("en0_shoot", 32'(SHOOT), 32'd1);
        check_eq("en0_fault", 32'(FAULT), 32'd1);
        HS = 1'b0; LS = 1'b0; cyc(4);
        pulse_clr;
        check_eq("en0_clr", 32'(SHOOT), 32'd0);
        EN = 1'b1; cyc(5);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
